// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide execute unit.
// Radix-2^BPC shift-add multiply and restoring divide over XLEN/BPC cycles.
module muldiv_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned L  = XLEN / BPC;
    localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        fn_q, fn_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   fast_res;
    logic [AW-1:0]     step_acc;
    logic [XLEN:0]     sum, rem_sh, diff;
    logic [AW-1:0]     prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   fix_res;

    // Operand decode: signedness per opcode, magnitudes, and fast-path detection.
    always_comb begin
        a_neg    = op_a[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                                    (funct3 == 3'b100) || (funct3 == 3'b110));
        b_neg    = op_b[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b100) ||
                                    (funct3 == 3'b110));
        mag_a    = a_neg ? ('0 - op_a) : op_a;
        mag_b    = b_neg ? ('0 - op_b) : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        fast_res = '0;
        if (div_zero) begin
            fast_res = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            fast_res = funct3[1] ? '0 : op_a;
        end
    end

    // One CALC cycle: BPC shift-add or restoring-division steps.
    always_comb begin
        step_acc = acc_q;
        sum      = '0;
        rem_sh   = '0;
        diff     = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (!fn_q[2]) begin
                sum      = {1'b0, step_acc[AW-1:XLEN]} + (step_acc[0] ? {1'b0, opnd_q} : '0);
                step_acc = {sum, step_acc[XLEN-1:1]};
            end else begin
                rem_sh = step_acc[AW-1:XLEN-1];
                diff   = rem_sh - {1'b0, opnd_q};
                if (!diff[XLEN]) begin
                    step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
                end else begin
                    step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    // Sign fix and field selection for the FIX state.
    always_comb begin
        prod = neg_q ? ('0 - acc_q) : acc_q;
        quo  = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem  = neg_q ? ('0 - acc_q[AW-1:XLEN]) : acc_q[AW-1:XLEN];
        case (fn_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[AW-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    // Next-state logic; abort overrides everything else.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fn_d     = fn_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    if (div_zero || div_ovf) begin
                        done_d   = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        fn_d    = funct3;
                        acc_d   = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                        opnd_d  = funct3[2] ? mag_b : mag_a;
                        neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                if (cnt_q == CW'(L - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                result_d = fix_res;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
            result_d = result_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fn_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fn_q     <= fn_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: three muldiv_unit instances (BPC=1,2,4) driven in lockstep
// and compared cycle by cycle against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              busy_w [3];
    logic              done_w [3];
    logic [XLEN-1:0]   res_w  [3];
    logic [XLEN-1:0]   prev_res [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .BPC(1)) u_bpc1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0])
    );
    muldiv_unit #(.XLEN(XLEN), .BPC(2)) u_bpc2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1])
    );
    muldiv_unit #(.XLEN(XLEN), .BPC(4)) u_bpc4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2])
    );

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb;                 return p[63:32]; end
            3'd2: begin p = sa * ub;                 return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1'b1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Launch one op and check busy/done/result of every instance for each following cycle.
    // abort_c/rst_c: cycle (1-based after the start cycle) in which abort/rst is driven, 0 = none.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int abort_c, input int rst_c, input bit with_abort,
                          input bit mid_start);
        logic [31:0] exp;
        bit          fast;
        bit          eb, ed;
        int          kill, maxc, lk;
        exp  = ref_model(f, a, b);
        fast = is_fast(f, a, b);
        kill = 1000;
        if (abort_c > 0) kill = abort_c;
        if (rst_c > 0 && rst_c < kill) kill = rst_c;
        maxc = fast ? 3 : 36;
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        abort  = with_abort;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk);
            #1;
            start = mid_start && (c == 3);
            if (start) funct3 = 3'($urandom_range(0, 7));
            abort = (c == abort_c);
            rst   = (c == rst_c);
            op_a  = $urandom;
            op_b  = $urandom;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                lk = 32 >> k;
                if (with_abort) begin
                    eb = 1'b0;
                    ed = 1'b0;
                end else if (fast) begin
                    eb = 1'b0;
                    ed = (c == 1);
                end else begin
                    eb = (c <= lk + 1) && (c <= kill);
                    ed = (c == lk + 2) && (kill > lk + 1);
                end
                if (ed) prev_res[k] = exp;
                if (rst_c > 0 && c == rst_c + 1) prev_res[k] = 32'd0;
                check("busy", k, 32'(busy_w[k]), 32'(eb));
                check("done", k, 32'(done_w[k]), 32'(ed));
                check("result", k, res_w[k], prev_res[k]);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            prev_res[k] = 32'd0;
            check("reset_busy", k, 32'(busy_w[k]), 32'd0);
            check("reset_done", k, 32'(done_w[k]), 32'd0);
            check("reset_result", k, res_w[k], 32'd0);
        end

        // Directed arithmetic cases
        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 0, 0, 1'b0, 1'b0);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 0, 0, 1'b0, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         0, 0, 1'b0, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         0, 0, 1'b0, 1'b0);
        run_op(3'd5, 32'd100,        32'd7,         0, 0, 1'b0, 1'b0);
        run_op(3'd7, 32'd100,        32'd7,         0, 0, 1'b0, 1'b0);
        run_op(3'd5, 32'd5,          32'd0,         0, 0, 1'b0, 1'b0);
        run_op(3'd7, 32'd5,          32'd0,         0, 0, 1'b0, 1'b0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
        run_op(3'd4, 32'd3,          32'hFFFF_FFF9, 0, 0, 1'b0, 1'b0);

        // Control cases: abort mid-CALC, start dropped with abort, ignored mid-op start, rst mid-CALC
        run_op(3'd0, 32'h1234_5678,  32'h0BAD_F00D, 10, 0, 1'b0, 1'b0);
        run_op(3'd4, 32'd1000,       32'd3,         0, 0, 1'b1, 1'b0);
        run_op(3'd1, 32'hDEAD_BEEF,  32'h7654_3210, 0, 0, 1'b0, 1'b1);
        run_op(3'd7, 32'hCAFE_0001,  32'd17,        0, 5, 1'b0, 1'b0);

        // Randomized operations with biased corner operands
        for (int n = 0; n < 48; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: rb = 32'd0;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                4: ra = 32'h8000_0000;
                default: rb = 32'hFFFF_FFFF;
            endcase
            run_op(rf, ra, rb, 0, 0, 1'b0, ($urandom_range(0, 3) == 0) && !is_fast(rf, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
